// File: rtl/data_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_ctrl
// Brief    : RV32I load/store controller over a word-organised RAM with a
//            configurable access latency. Optional macro
//            DATA_RAM_MISALIGN_ERR_EN rejects misaligned H/HU/W accesses.
// Revision : 1.0
// ============================================================================
module data_ram_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          c_IDX_W    = ADDR_W - 2;
  localparam int          c_DEPTH    = 2 ** c_IDX_W;
  localparam logic [2:0]  c_CNT_LOAD = 3'((WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0);

  localparam logic [1:0]  c_S_IDLE = 2'd0;
  localparam logic [1:0]  c_S_WAIT = 2'd1;
  localparam logic [1:0]  c_S_RESP = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [2:0]         r_cnt;
  logic               r_we;
  logic [2:0]         r_funct3;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_err;
  logic [31:0]        r_mem [0:c_DEPTH-1];

  logic               w_accept;
  logic               w_enter_resp;
  logic               w_we;
  logic [2:0]         w_funct3;
  logic [31:0]        w_addr;
  logic [31:0]        w_wdata;
  logic [c_IDX_W-1:0] w_idx;
  logic [31:0]        w_old;
  logic               w_err;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_load;
  logic [3:0]         w_be;
  logic [31:0]        w_wd;
  logic [31:0]        w_wmerge;

  assign w_accept = req_valid && req_ready;

  // With zero wait states the array is touched on the acceptance edge itself,
  // so the access fields come straight from the request port in IDLE.
  assign w_enter_resp = (w_accept && (WAIT_CYC == 0)) ||
                        ((r_state == c_S_WAIT) && (r_cnt == 3'd0));
  assign w_we     = (r_state == c_S_IDLE) ? req_we     : r_we;
  assign w_funct3 = (r_state == c_S_IDLE) ? req_funct3 : r_funct3;
  assign w_addr   = (r_state == c_S_IDLE) ? req_addr   : r_addr;
  assign w_wdata  = (r_state == c_S_IDLE) ? req_wdata  : r_wdata;
  assign w_idx    = w_addr[ADDR_W-1:2];
  assign w_old    = r_mem[w_idx];

  always_comb begin
    w_err = 1'b0;
    if ((w_addr >> ADDR_W) != 32'd0)                        w_err = 1'b1;
    if ((w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11))   w_err = 1'b1;
    if (w_we && w_funct3[2])                                w_err = 1'b1;
`ifdef DATA_RAM_MISALIGN_ERR_EN
    if ((w_funct3[1:0] == 2'b01) && w_addr[0])              w_err = 1'b1;
    if ((w_funct3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00)) w_err = 1'b1;
`endif
  end

  always_comb begin
    w_byte = 8'd0;
    case (w_addr[1:0])
      2'b00:   w_byte = w_old[7:0];
      2'b01:   w_byte = w_old[15:8];
      2'b10:   w_byte = w_old[23:16];
      default: w_byte = w_old[31:24];
    endcase
    w_half = w_addr[1] ? w_old[31:16] : w_old[15:0];
    w_load = 32'd0;
    case (w_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      3'b010:  w_load = w_old;
      default: w_load = 32'd0;
    endcase
  end

  always_comb begin
    w_be = 4'b0000;
    w_wd = w_wdata;
    case (w_funct3[1:0])
      2'b00: begin
        w_be = 4'b0001 << w_addr[1:0];
        w_wd = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{w_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
    w_wmerge = w_old;
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) w_wmerge[8*b +: 8] = w_wd[8*b +: 8];
    end
  end

  // Array has no reset; the reset gate keeps an aborted access from committing.
  always_ff @(posedge clk) begin
    if (!reset && w_enter_resp && w_we && !w_err) begin
      r_mem[w_idx] <= w_wmerge;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE: if (req_valid)          w_next_state = (WAIT_CYC == 0) ? c_S_RESP : c_S_WAIT;
      c_S_WAIT: if (r_cnt == 3'd0)      w_next_state = c_S_RESP;
      c_S_RESP: if (rsp_ready)          w_next_state = c_S_IDLE;
      default:                          w_next_state = c_S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == c_S_IDLE);
    rsp_valid = (r_state == c_S_RESP);
    rsp_rdata = r_rdata;
    rsp_err   = r_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= 3'd0;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_cnt    <= c_CNT_LOAD;
      end else if ((r_state == c_S_WAIT) && (r_cnt != 3'd0)) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_enter_resp) begin
        r_rdata <= (w_we || w_err) ? 32'd0 : w_load;
        r_err   <= w_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_ram_ctrl
// Brief    : Scoreboard bench for data_ram_ctrl with directed load/store vectors.
// Revision : 1.0
// ============================================================================
module tb_data_ram_ctrl;

  localparam int ADDR_W   = 10;
  localparam int WAIT_CYC = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  logic prev_valid = 1'b0;

  data_ram_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else             n_pass++;
  endtask

  // Monitor: latency on the first cycle of each response, data on its handshake.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid <= 1'b0;
    end else begin
      if (rsp_valid && !prev_valid) begin
        if (q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else               chk("latency", 32'(cyc - q[0].cyc), 32'(WAIT_CYC + 1));
      end
      if (rsp_valid && rsp_ready && (q.size() > 0)) begin
        chk("rsp_rdata", rsp_rdata, q[0].rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, q[0].err});
        void'(q.pop_front());
      end
      prev_valid <= rsp_valid;
    end
  end

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee,
                      input bit push);
    @(posedge clk); #1;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    if (push) q.push_back('{er, ee, cyc});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q.size() != 0) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("rsp_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee);
    send(we, f3, addr, wd, er, ee, 1'b1);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    @(negedge clk);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);

    // word / byte loads with sign and zero extension
    xfer(1'b1, 3'b010, 32'h10, 32'h8000_00F1, 32'h0, 1'b0);
    xfer(1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFF1, 1'b0);
    xfer(1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_0080, 1'b0);
    xfer(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_8000, 1'b0);
    xfer(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_8000, 1'b0);

    // partial stores merge into the existing word
    xfer(1'b1, 3'b010, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
    xfer(1'b1, 3'b000, 32'h21, 32'h0000_00AB, 32'h0, 1'b0);
    xfer(1'b0, 3'b010, 32'h20, 32'h0, 32'h1122_AB44, 1'b0);
    xfer(1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 32'h0, 1'b0);
    xfer(1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEF_AB44, 1'b0);
    xfer(1'b0, 3'b101, 32'h22, 32'h0, 32'h0000_BEEF, 1'b0);
    xfer(1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF_BEEF, 1'b0);

    // out-of-range and illegal encodings
    xfer(1'b1, 3'b010, 32'h0, 32'hCAFE_F00D, 32'h0, 1'b0);
    xfer(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1);
    xfer(1'b1, 3'b010, 32'h400, 32'h1234_5678, 32'h0, 1'b1);
    xfer(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1);
    xfer(1'b1, 3'b100, 32'h0, 32'h0000_00FF, 32'h0, 1'b1);
    xfer(1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0);

    // response held under back-pressure
    rsp_ready = 1'b0;
    send(1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEF_AB44, 1'b0, 1'b1);
    n = 0;
    while (!rsp_valid && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid_seen", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rdata", rsp_rdata, 32'hBEEF_AB44);
      chk("stall_err", {31'd0, rsp_err}, 32'd0);
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_done();

    // reset while the store waits must not commit it
    xfer(1'b1, 3'b010, 32'h30, 32'h0, 32'h0, 1'b0);
    send(1'b1, 3'b010, 32'h30, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("abort_rsp_valid2", {31'd0, rsp_valid}, 32'd0);
    xfer(1'b0, 3'b010, 32'h30, 32'h0, 32'h0, 1'b0);

`ifdef DATA_RAM_MISALIGN_ERR_EN
    xfer(1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1);
`else
    xfer(1'b0, 3'b001, 32'h11, 32'h0, 32'h0000_00F1, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
